switch_allocator: RTL

Per-router switch allocator sitting between the five input FIFO buffers (N=0, S=1, E=2, W=3, L=4) and the 5x5 crossbar. Each cycle it matches non-empty input queues to their requested output ports. Each output port uses an independent round-robin arbiter. The allocator pops the winning queues and drives registered crossbar selects and output-valid strobes. Packets are single-flit, so there is no wormhole locking.

---
 rtl/switch_allocator.sv | 89 ++++++++
 1 files changed

// File: rtl/switch_allocator.sv
// Switch allocator for a 5-port router. Each output has its own round-robin arbiter.
// Winning input queues are popped, and the crossbar selects and valids are registered.
module switch_allocator #(
    parameter int NPORTS = 5,
    parameter int PW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req_valid_i,
    input  logic [NPORTS*PW-1:0] req_port_i,
    input  logic [NPORTS-1:0]    out_ready_i,
    output logic [NPORTS-1:0]    pop_req_o,
    output logic [NPORTS*PW-1:0] xbar_sel_o,
    output logic [NPORTS-1:0]    out_valid_o,
    output logic                 bad_port_o
);

    logic [PW-1:0]     rr_ptr    [NPORTS];
    logic [NPORTS-1:0] req_mat   [NPORTS];
    logic [PW-1:0]     grant_idx [NPORTS];
    logic [NPORTS-1:0] grant_hit;
    logic              bad_now;

    // req_mat[j][i]: input i wants output j; out-of-range ports match no output
    always_comb begin
        bad_now = 1'b0;
        for (int j = 0; j < NPORTS; j++) begin
            req_mat[j] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (req_valid_i[i] && (req_port_i[PW*i +: PW] == PW'(j)))
                    req_mat[j][i] = 1'b1;
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (req_valid_i[i] && (req_port_i[PW*i +: PW] >= PW'(NPORTS)))
                bad_now = 1'b1;
        end
    end

    always_comb begin
        logic [PW:0] idx;
        idx = '0;
        for (int j = 0; j < NPORTS; j++) begin
            grant_hit[j] = 1'b0;
            grant_idx[j] = '0;
            for (int k = 0; k < NPORTS; k++) begin
                idx = {1'b0, rr_ptr[j]} + (PW+1)'(k);
                if (idx >= (PW+1)'(NPORTS))
                    idx = idx - (PW+1)'(NPORTS);
                if (out_ready_i[j] && !grant_hit[j] && req_mat[j][idx[PW-1:0]]) begin
                    grant_hit[j] = 1'b1;
                    grant_idx[j] = idx[PW-1:0];
                end
            end
        end
    end

    // Each input names one port, so at most one output can grant it
    always_comb begin
        pop_req_o = '0;
        if (!rst) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (grant_hit[j])
                    pop_req_o[grant_idx[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NPORTS; j++)
                rr_ptr[j] <= '0;
            xbar_sel_o  <= '0;
            out_valid_o <= '0;
            bad_port_o  <= 1'b0;
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                out_valid_o[j] <= grant_hit[j];
                if (grant_hit[j]) begin
                    rr_ptr[j] <= (grant_idx[j] == PW'(NPORTS-1)) ? '0 : grant_idx[j] + PW'(1);
                    xbar_sel_o[PW*j +: PW] <= grant_idx[j];
                end
            end
            if (bad_now)
                bad_port_o <= 1'b1;
        end
    end

endmodule
